// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. queued multicycle results, plus pending scoreboard.
// Optional MC_BYPASS_EN: an mc result may drive the port directly when the FIFO is empty and wb is idle.
module rf_wb_arbiter #(
  parameter int MC_DEPTH   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_wa,
  input  logic [31:0] wb_wd,
  input  logic        mc_valid,
  output logic        mc_ready,
  input  logic [4:0]  mc_wa,
  input  logic [31:0] mc_wd,
  input  logic        issue_valid,
  input  logic [4:0]  issue_wa,
  output logic        issue_ready,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic        hazard,
  output logic        wb_stall,
  output logic        we3,
  output logic [4:0]  wa3,
  output logic [31:0] wd3,
  output logic [31:0] pending
);

  localparam int PW = $clog2(MC_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
  } mc_entry_t;

  mc_entry_t       mem [MC_DEPTH];
  mc_entry_t       head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_next;
  logic [SW-1:0]   starve;
  logic            ready_q;
  logic [31:0]     pend_q;

  logic            fifo_empty, force_mc, fifo_grant, bypass, push, pop;
  logic            clr_en;
  logic [4:0]      clr_wa;
  logic [31:0]     set_mask, clr_mask;

  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];
  assign force_mc   = !fifo_empty && (starve == SW'(STARVE_MAX));
  assign fifo_grant = !reset && !fifo_empty && (force_mc || !wb_we);

`ifdef MC_BYPASS_EN
  assign bypass   = !reset && fifo_empty && !wb_we && (starve == '0) && mc_valid;
  assign mc_ready = (ready_q && !reset) || bypass;
`else
  assign bypass   = 1'b0;
  assign mc_ready = ready_q && !reset;
`endif

  // Bypassed results go straight to the port and never occupy a slot.
  assign push       = mc_valid && mc_ready && !bypass;
  assign pop        = fifo_grant;
  assign count_next = count + CW'(push) - CW'(pop);

  assign wb_stall    = !reset && force_mc;
  assign hazard      = !reset && (pend_q[ra1] || pend_q[ra2]);
  assign issue_ready = (issue_wa == 5'd0) || !pend_q[issue_wa];
  assign pending     = pend_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    we3    = 1'b0;
    wa3    = 5'd0;
    wd3    = 32'd0;
    clr_en = 1'b0;
    clr_wa = 5'd0;
    if (fifo_grant) begin
      we3    = (head.wa != 5'd0);
      wa3    = head.wa;
      wd3    = head.wd;
      clr_en = 1'b1;
      clr_wa = head.wa;
    end else if (!reset && wb_we) begin
      we3 = (wb_wa != 5'd0);
      wa3 = wb_wa;
      wd3 = wb_wd;
    end else if (bypass) begin
      we3    = (mc_wa != 5'd0);
      wa3    = mc_wa;
      wd3    = mc_wd;
      clr_en = 1'b1;
      clr_wa = mc_wa;
    end
  end

  always_comb begin
    set_mask = 32'd0;
    clr_mask = 32'd0;
    if (issue_valid && issue_ready && issue_wa != 5'd0)
      set_mask = 32'd1 << issue_wa;
    if (clr_en)
      clr_mask = 32'd1 << clr_wa;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      starve  <= '0;
      ready_q <= 1'b0;
      pend_q  <= 32'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count   <= count_next;
      ready_q <= (count_next != CW'(MC_DEPTH));
      if (fifo_empty || fifo_grant)
        starve <= '0;
      else if (starve != SW'(STARVE_MAX))
        starve <= starve + SW'(1);
      // Set is applied after clear so a same-cycle issue keeps the register pending.
      pend_q <= ((pend_q & ~clr_mask) | set_mask) & ~32'd1;
    end
  end

  // NOTE: FIFO storage carries no reset; occupancy and pointers alone define which slots are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{wa: mc_wa, wd: mc_wd};
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: expected port writes are queued at stimulus time and
// compared as the write port fires; directed checks cover stall, backpressure and scoreboard.
module tb_rf_wb_arbiter;

`ifdef MC_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_wa;
  logic [31:0] mc_wd;
  logic        issue_valid;
  logic [4:0]  issue_wa;
  logic        issue_ready;
  logic [4:0]  ra1, ra2;
  logic        hazard, wb_stall, we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [31:0] pending;

  int n_checks = 0;
  int n_pass   = 0;
  logic [36:0] exp_q [$];
  logic [31:0] exp_pend = 32'd0;

  rf_wb_arbiter #(.MC_DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_wa(mc_wa), .mc_wd(mc_wd),
    .issue_valid(issue_valid), .issue_wa(issue_wa), .issue_ready(issue_ready),
    .ra1(ra1), .ra2(ra2), .hazard(hazard), .wb_stall(wb_stall),
    .we3(we3), .wa3(wa3), .wd3(wd3), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Scoreboard: every port write must match the oldest expected write.
  always @(negedge clk) begin
    if (we3) begin
      if (exp_q.size() == 0)
        check("sb_unexpected", {27'd0, wa3, wd3}, 64'd0);
      else
        check("sb_write", {27'd0, wa3, wd3}, {27'd0, exp_q.pop_front()});
    end
  end

  task automatic drive_wb(input logic en, input logic [4:0] wa, input logic [31:0] wd, input logic expect_write);
    wb_we = en; wb_wa = wa; wb_wd = wd;
    if (expect_write) exp_q.push_back({wa, wd});
  endtask

  task automatic drive_mc(input logic v, input logic [4:0] wa, input logic [31:0] wd);
    mc_valid = v; mc_wa = wa; mc_wd = wd;
  endtask

  initial begin
    reset = 1'b1; wb_we = 1'b1; wb_wa = 5'd3; wb_wd = 32'h1111;
    mc_valid = 1'b0; mc_wa = 5'd0; mc_wd = 32'd0;
    issue_valid = 1'b0; issue_wa = 5'd0; ra1 = 5'd0; ra2 = 5'd0;

    // 1: reset held two cycles with wb_we asserted
    step();
    at_neg();
    check("rst_we3", {63'd0, we3}, 64'd0);
    check("rst_mc_ready", {63'd0, mc_ready}, 64'd0);
    step();
    at_neg();
    check("rst_pending", {32'd0, pending}, 64'd0);
    check("rst_stall", {63'd0, wb_stall}, 64'd0);
    #1 reset = 1'b0; wb_we = 1'b0;
    step();
    at_neg();
    check("rel_mc_ready", {63'd0, mc_ready}, 64'd1);

    // 2: issue to r5, then the result arrives with wb idle
    step();
    issue_valid = 1'b1; issue_wa = 5'd5; ra1 = 5'd5;
    at_neg();
    check("iss5_ready", {63'd0, issue_ready}, 64'd1);
    step();
    issue_valid = 1'b0;
    exp_pend[5] = 1'b1;
    at_neg();
    check("iss5_pend", {32'd0, pending}, {32'd0, exp_pend});
    check("iss5_hazard", {63'd0, hazard}, 64'd1);
    step();
    drive_mc(1'b1, 5'd5, 32'hDEADBEEF);
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    at_neg();
    check("mc5_haz_accept", {63'd0, hazard}, 64'd1);
    step();
    drive_mc(1'b0, 5'd0, 32'd0);
    at_neg();
    check("mc5_haz_write", {63'd0, hazard}, {63'd0, !BYP});
    step();
    exp_pend[5] = 1'b0;
    at_neg();
    check("mc5_haz_after", {63'd0, hazard}, 64'd0);

    // 3: wb busy every cycle; one queued mc entry starves for 4 cycles then forces a stall
    step();
    drive_wb(1'b1, 5'd10, 32'h100, 1'b1);
    drive_mc(1'b1, 5'd11, 32'hA11);
    at_neg();
    check("st_stall0", {63'd0, wb_stall}, 64'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      drive_mc(1'b0, 5'd0, 32'd0);
      drive_wb(1'b1, 5'd10, 32'h100 + i, 1'b1);
      at_neg();
      check($sformatf("st_stall%0d", i), {63'd0, wb_stall}, 64'd0);
    end
    step();
    drive_wb(1'b1, 5'd10, 32'h105, 1'b0);
    exp_q.push_back({5'd11, 32'hA11});
    at_neg();
    check("st_stall5", {63'd0, wb_stall}, 64'd1);
    step();
    drive_wb(1'b1, 5'd10, 32'h105, 1'b1);
    at_neg();
    check("st_stall6", {63'd0, wb_stall}, 64'd0);

    // 4: fill the FIFO behind a busy wb, producer holds on backpressure, drain in order
    step();
    drive_wb(1'b1, 5'd12, 32'h200, 1'b1);
    drive_mc(1'b1, 5'd3, 32'h333);
    step();
    drive_wb(1'b1, 5'd12, 32'h201, 1'b1);
    drive_mc(1'b1, 5'd4, 32'h444);
    at_neg();
    check("ff_ready_c1", {63'd0, mc_ready}, 64'd1);
    step();
    drive_wb(1'b1, 5'd12, 32'h202, 1'b1);
    drive_mc(1'b1, 5'd6, 32'h666);
    at_neg();
    check("ff_ready_full", {63'd0, mc_ready}, 64'd0);
    step();
    drive_wb(1'b0, 5'd0, 32'd0, 1'b0);
    exp_q.push_back({5'd3, 32'h333});
    at_neg();
    check("ff_ready_pop", {63'd0, mc_ready}, 64'd0);
    step();
    exp_q.push_back({5'd4, 32'h444});
    at_neg();
    check("ff_ready_pushpop", {63'd0, mc_ready}, 64'd1);
    step();
    drive_mc(1'b0, 5'd0, 32'd0);
    exp_q.push_back({5'd6, 32'h666});
    at_neg();
    check("ff_ready_drain", {63'd0, mc_ready}, 64'd1);

    // 5: issue blocked on pending register; same-cycle set/clear of r9
    step();
    issue_valid = 1'b1; issue_wa = 5'd7;
    step();
    exp_pend[7] = 1'b1;
    at_neg();
    check("iss7_blocked", {63'd0, issue_ready}, 64'd0);
    step();
    issue_valid = 1'b0;
    at_neg();
    check("iss7_nochg", {32'd0, pending}, {32'd0, exp_pend});
    step();
    drive_wb(1'b1, 5'd13, 32'h300, 1'b1);
    drive_mc(1'b1, 5'd9, 32'h999);
    step();
    drive_wb(1'b0, 5'd0, 32'd0, 1'b0);
    drive_mc(1'b0, 5'd0, 32'd0);
    exp_q.push_back({5'd9, 32'h999});
    issue_valid = 1'b1; issue_wa = 5'd9;
    at_neg();
    check("iss9_ready", {63'd0, issue_ready}, 64'd1);
    step();
    issue_valid = 1'b0; ra2 = 5'd9;
    exp_pend[9] = 1'b1;
    at_neg();
    check("setclr_pend", {32'd0, pending}, {32'd0, exp_pend});
    check("setclr_hazard", {63'd0, hazard}, 64'd1);

    // 6: r0 entries and r0 writeback never assert we3
    step();
    ra1 = 5'd0; ra2 = 5'd0;
    drive_wb(1'b1, 5'd14, 32'h400, 1'b1);
    drive_mc(1'b1, 5'd0, 32'h1234);
    step();
    drive_wb(1'b0, 5'd0, 32'd0, 1'b0);
    drive_mc(1'b0, 5'd0, 32'd0);
    at_neg();
    check("r0_mc_we3", {63'd0, we3}, 64'd0);
    step();
    drive_wb(1'b1, 5'd0, 32'h777, 1'b0);
    at_neg();
    check("r0_wb_we3", {63'd0, we3}, 64'd0);
    step();
    drive_wb(1'b0, 5'd0, 32'd0, 1'b0);
    drive_mc(1'b1, 5'd2, 32'h55);
    exp_q.push_back({5'd2, 32'h55});
    at_neg();
    check("mc2_ready", {63'd0, mc_ready}, 64'd1);
    check("mc2_same_cycle", {63'd0, we3}, {63'd0, BYP});
    step();
    drive_mc(1'b0, 5'd0, 32'd0);

    // Drain and final state
    for (int i = 0; i < 4; i++) step();
    ra1 = 5'd7;
    at_neg();
    check("sb_drain", 64'(exp_q.size()), 64'd0);
    check("final_pend", {32'd0, pending}, {32'd0, exp_pend});
    check("final_hazard7", {63'd0, hazard}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
